uart_rx: RTL

//  8N1 UART receiver, LSB first, one start bit, one stop bit, no parity; the receive-side counterpart of the console transmitter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// The bit period is shared with the console transmitter so both sides agree on baud rate.
package uart_pkg;

  // 100 MHz system clock divided down to 9600 baud
  localparam int UART_CYCLES_PER_BIT = 10416;

  // 8N1 framing: eight data bits, LSB first
  localparam int UART_DATA_BITS = 8;

  // Receiver state encoding
  localparam logic [2:0] RX_ENC_IDLE      = 3'd0;
  localparam logic [2:0] RX_ENC_START     = 3'd1;
  localparam logic [2:0] RX_ENC_DATA      = 3'd2;
  localparam logic [2:0] RX_ENC_STOP      = 3'd3;
  localparam logic [2:0] RX_ENC_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE      = RX_ENC_IDLE,
    RX_START     = RX_ENC_START,
    RX_DATA      = RX_ENC_DATA,
    RX_STOP      = RX_ENC_STOP,
    RX_WAIT_HIGH = RX_ENC_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the clk domain.
// RESET_VALUE lets the caller pick the idle level, so a serial line does not look
// active while the system comes out of reset.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. The rx pin is synchronised, the start bit is
// confirmed at its midpoint, and every following bit is sampled at mid-bit.
// Received bytes go into a one-entry valid/ready holding register; framing
// errors and bytes dropped because the register is full are reported as
// single-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = UART_CYCLES_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);

  // Last count of the half-bit wait in START and of a full bit in DATA/STOP
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rxs;
  logic                      commit;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start
  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  // A good stop bit hands the assembled byte to the holding register this cycle
  assign commit = (state == RX_STOP) && (cnt == BIT_LAST) && rxs;

  assign busy = (state != RX_IDLE);

  // Frame sequencer: cnt is cleared on every state change so it never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end

        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= RX_IDLE;
            end else begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_WAIT_HIGH: begin
          if (rxs) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= RX_IDLE;
        end
      endcase
    end
  end

  // One-entry holding register; a full register with no consumer drops the new byte
  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
